// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer and its prescaler.
package debounce_pkg;

    // Bit 1 of the encoding is the debounced level.
    typedef enum logic [1:0] {
        StZero  = 2'b00,
        StWait1 = 2'b01,
        StOne   = 2'b10,
        StWait0 = 2'b11
    } state_t;

    localparam int unsigned DefaultCntW        = 19;
    localparam int unsigned DefaultStableTicks = 3;

    // Width of the stable-tick counter: max(1, clog2(ticks)).
    function automatic int unsigned tick_cnt_width(input int unsigned ticks);
        return (ticks <= 2) ? 1 : $clog2(ticks);
    endfunction

endpackage

// File: rtl/mod_m_tick.sv
// Free-running prescaler: m_tick is high for one cycle every 2^CNT_W cycles.
module mod_m_tick #(
    parameter int unsigned CNT_W = debounce_pkg::DefaultCntW
) (
    input  logic clk,
    input  logic reset,
    output logic m_tick
);

    logic [CNT_W-1:0] q_q;

    // Counter wraps naturally; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign m_tick = (q_q == {CNT_W{1'b1}});

endmodule

// File: rtl/debounce_in.sv
// Switch debouncer: level changes only after STABLE_TICKS consecutive sample ticks of
// stable input; db_tick pulses on the first cycle of each qualified rise.
// Optional macro DEBOUNCE_SYNC_EN inserts a two-flop synchronizer on sw.
module debounce_in
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W        = DefaultCntW,
    parameter int unsigned STABLE_TICKS = DefaultStableTicks
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    localparam int unsigned N_W = tick_cnt_width(STABLE_TICKS);
    localparam logic [N_W-1:0] LastN = N_W'(STABLE_TICKS - 1);

    logic           m_tick;
    logic           s;
    state_t         state_q, state_d;
    logic [N_W-1:0] n_q, n_d;
    logic           db_tick_q;

    mod_m_tick #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .m_tick (m_tick)
    );

`ifdef DEBOUNCE_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchronizer so sw may come straight from a pad.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = sw;
`endif

    // State, tick counter and registered rise pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StZero;
            n_q       <= '0;
            db_tick_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            db_tick_q <= (state_q == StWait1) && (state_d == StOne);
        end
    end

    // Next state: an opposite sample in a wait state aborts before any tick is counted.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        case (state_q)
            StZero: begin
                if (s) begin
                    state_d = StWait1;
                    n_d     = '0;
                end
            end
            StWait1: begin
                if (!s) begin
                    state_d = StZero;
                end else if (m_tick) begin
                    if (n_q == LastN) state_d = StOne;
                    else              n_d     = n_q + N_W'(1);
                end
            end
            StOne: begin
                if (!s) begin
                    state_d = StWait0;
                    n_d     = '0;
                end
            end
            StWait0: begin
                if (s) begin
                    state_d = StOne;
                end else if (m_tick) begin
                    if (n_q == LastN) state_d = StZero;
                    else              n_d     = n_q + N_W'(1);
                end
            end
            default: state_d = StZero;
        endcase
    end

    assign db_level = (state_q == StOne) || (state_q == StWait0);
    assign db_tick  = db_tick_q;

endmodule

// File: tb/tb_debounce_in.sv
// Randomized and directed bench for debounce_in with a scoreboard fed by a
// count-of-ticks reference model.
module tb_debounce_in;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned STABLE = 3;
    localparam int          PERIOD = 1 << CNT_W;
`ifdef DEBOUNCE_SYNC_EN
    localparam int          SYNC_LAT = 2;
`else
    localparam int          SYNC_LAT = 0;
`endif
    // Prescaler phase is anchored to reset release, so ticks land on edges 16, 32, 48
    // regardless of the short synchronizer lag; a held input rises on edge 48.
    localparam int          RISE_EDGE = STABLE * PERIOD;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sw = 1'b0;
    logic db_level;
    logic db_tick;

    int checks   = 0;
    int failures = 0;
    int tick_seen = 0;

    logic [1:0] exp_q[$];

    // Reference model: level flips once STABLE tick edges have elapsed since the
    // candidate level was first seen, counted as floor(k/P) - floor(start/P).
    int   m_k     = 0;
    int   m_start = 0;
    logic m_pend  = 1'b0;
    logic m_level = 1'b0;
    logic m_rose  = 1'b0;
    logic [1:0] m_hist = 2'b00;

    always #5 clk = ~clk;

    debounce_in #(
        .CNT_W        (CNT_W),
        .STABLE_TICKS (STABLE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic s_in, input logic r_in);
        logic s_eff;
        m_rose = 1'b0;
        if (r_in) begin
            m_k = 0; m_pend = 1'b0; m_level = 1'b0; m_hist = 2'b00;
        end else begin
            if (SYNC_LAT == 2) begin
                s_eff  = m_hist[1];
                m_hist = {m_hist[0], s_in};
            end else begin
                s_eff = s_in;
            end
            m_k++;
            if (s_eff == m_level) begin
                m_pend = 1'b0;
            end else if (!m_pend) begin
                m_pend  = 1'b1;
                m_start = m_k;
            end else if ((m_k / PERIOD) - (m_start / PERIOD) == STABLE) begin
                m_level = s_eff;
                m_pend  = 1'b0;
                m_rose  = s_eff;
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, push the expected outputs.
    task automatic cycle(input logic s_in, input logic r_in);
        sw    = s_in;
        reset = r_in;
        @(posedge clk);
        model_edge(s_in, r_in);
        exp_q.push_back({m_level, m_rose});
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
    endtask

    // Hold sw high up to 60 edges and report the first edge with db_level high.
    task automatic hold_high_rise(output int rise_at);
        rise_at = 0;
        for (int i = 1; i <= 60; i++) begin
            cycle(1'b1, 1'b0);
            if (db_level && rise_at == 0) rise_at = i;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per clock and compares.
    always @(negedge clk) begin
        logic [1:0] e;
        if (db_tick) tick_seen++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_level", int'(db_level), int'(e[1]));
            check("sb_tick", int'(db_tick), int'(e[0]));
        end
    end

    initial begin
        int rise_at;
        int t0;

        // Reset state and test 1: held high from reset release.
        do_reset();
        settle();
        check("reset_level", int'(db_level), 0);
        check("reset_tick", int'(db_tick), 0);
        t0 = tick_seen;
        hold_high_rise(rise_at);
        settle();
        check("t1_rise_edge", rise_at, RISE_EDGE);
        check("t1_tick_count", tick_seen - t0, 1);

        // Test 4: release with a one-cycle blip mid-WAIT0.
        t0 = tick_seen;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
        check("t4_blip_held", int'(db_level), 1);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0);
        settle();
        check("t4_fell", int'(db_level), 0);
        check("t4_no_tick", tick_seen - t0, 0);

        // Test 2: short glitch from ZERO.
        do_reset();
        t0 = tick_seen;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 60; i++) cycle(1'b0, 1'b0);
        settle();
        check("t2_level", int'(db_level), 0);
        check("t2_no_tick", tick_seen - t0, 0);

        // Test 3: bounce every 3 cycles, then hold high.
        t0 = tick_seen;
        for (int i = 0; i < 40; i++) cycle(((i / 3) % 2) == 0, 1'b0);
        check("t3_no_tick_bounce", tick_seen - t0, 0);
        for (int i = 0; i < 70; i++) cycle(1'b1, 1'b0);
        settle();
        check("t3_level", int'(db_level), 1);
        check("t3_one_tick", tick_seen - t0, 1);

        // Test 5a: sw drops exactly as the final qualifying tick is sampled.
        do_reset();
        t0 = tick_seen;
        for (int i = 1; i < RISE_EDGE - SYNC_LAT; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
        settle();
        check("t5_prio_level", int'(db_level), 0);
        check("t5_prio_tick", tick_seen - t0, 0);

        // Test 5b: reset mid-WAIT1 forces full requalification.
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        hold_high_rise(rise_at);
        check("t5_reset_requal", rise_at, RISE_EDGE);

        // Random segments with occasional resets.
        for (int seg = 0; seg < 300; seg++) begin
            logic lv;
            int   len;
            lv  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 45);
            if ($urandom_range(0, 39) == 0) cycle(lv, 1'b1);
            for (int i = 0; i < len; i++) cycle(lv, 1'b0);
        end

        settle();
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
